// File: rtl/bsg_counter_overflow_ctrl_pkg.sv
// Shared types for the overflow-counter control stage: FSM state encoding
// and the sizing helper for the tick backlog counter.
package bsg_counter_overflow_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_e;

    // Bits needed to hold a backlog count of 0..pending_max inclusive.
    function automatic int backlog_width(input int pending_max);
        return $clog2(pending_max + 1);
    endfunction

endpackage

// File: rtl/bsg_counter_overflow_ctrl_prescaler.sv
// Prescale divider: while running, pulses en_o once every (divide_i+1) cycles.
// clear_i restarts the phase so the first pulse lands divide_i cycles later.
module bsg_counter_overflow_ctrl_prescaler #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               run_i,
    input  logic [width_p-1:0] divide_i,
    output logic               en_o
);

    logic [width_p-1:0] count_q, count_d;

    assign en_o = run_i & (count_q == divide_i);

    always_comb begin
        // NOTE: the hold value is assigned first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (run_i) begin
            count_d = en_o ? '0 : count_q + 1'b1;
        end
    end

    // NOTE: state registers take non-blocking assignments only.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bsg_counter_overflow_ctrl.sv
// Control stage for the overflow counter: config, set/enable with auto-reload,
// and a saturating tick backlog. Optional one-shot: BSG_COUNTER_OVERFLOW_CTRL_ONESHOT_EN.
module bsg_counter_overflow_ctrl
    import bsg_counter_overflow_ctrl_pkg::*;
#(
    parameter int width_p          = 31,
    parameter int prescale_width_p = 8,
    parameter int pending_max_p    = 3
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        cfg_v_i,
    input  logic [width_p-1:0]          cfg_start_i,
    input  logic [prescale_width_p-1:0] cfg_prescale_i,
`ifdef BSG_COUNTER_OVERFLOW_CTRL_ONESHOT_EN
    input  logic                        cfg_oneshot_i,
`endif
    output logic                        cfg_ready_o,
    input  logic                        start_i,
    input  logic                        stop_i,
    output logic                        ctr_set_o,
    output logic [width_p-1:0]          ctr_val_o,
    output logic                        ctr_en_o,
    input  logic                        ctr_overflow_i,
    output logic                        tick_v_o,
    input  logic                        tick_yumi_i,
    output logic                        lost_o,
    output logic                        busy_o
);

    localparam int backlog_w_lp = backlog_width(pending_max_p);
    localparam logic [backlog_w_lp-1:0] backlog_max_lp = backlog_w_lp'(pending_max_p);

    state_e                      state_q, state_d;
    logic [width_p-1:0]          start_q, start_d;
    logic [prescale_width_p-1:0] prescale_q, prescale_d;
    logic [backlog_w_lp-1:0]     backlog_q, backlog_d;
    logic                        lost_q, lost_d;

    logic run, tick_event, yumi, oneshot_hit;

    assign run        = (state_q == ST_RUN);
    assign tick_event = run & ctr_overflow_i;
    assign yumi       = tick_yumi_i & tick_v_o;

`ifdef BSG_COUNTER_OVERFLOW_CTRL_ONESHOT_EN
    logic oneshot_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            oneshot_q <= 1'b0;
        end else if (cfg_ready_o && cfg_v_i) begin
            oneshot_q <= cfg_oneshot_i;
        end
    end

    assign oneshot_hit = oneshot_q;
`else
    assign oneshot_hit = 1'b0;
`endif

    bsg_counter_overflow_ctrl_prescaler #(
        .width_p(prescale_width_p)
    ) prescaler (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clear_i  (state_q == ST_LOAD),
        .run_i    (run),
        .divide_i (prescale_q),
        .en_o     (ctr_en_o)
    );

    // Set outranks the counter's own wrap, so an overflow reloads start_q.
    assign ctr_set_o   = (state_q == ST_LOAD) | (tick_event & ~oneshot_hit);
    assign ctr_val_o   = start_q;
    assign cfg_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign tick_v_o    = (backlog_q != '0);
    assign lost_o      = lost_q;

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        prescale_d = prescale_q;
        lost_d     = lost_q;
        backlog_d  = backlog_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_v_i) begin
                    start_d    = cfg_start_i;
                    prescale_d = cfg_prescale_i;
                    lost_d     = 1'b0;
                end
                if (start_i && !stop_i) state_d = ST_LOAD;
            end
            ST_LOAD: state_d = stop_i ? ST_IDLE : ST_RUN;
            ST_RUN:  if (stop_i || (tick_event && oneshot_hit)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // An event and a yumi in the same cycle cancel out.
        if (tick_event && !yumi) begin
            if (backlog_q == backlog_max_lp) lost_d = 1'b1;
            else                             backlog_d = backlog_q + 1'b1;
        end else if (yumi && !tick_event) begin
            backlog_d = backlog_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            start_q    <= '0;
            prescale_q <= '0;
            backlog_q  <= '0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            prescale_q <= prescale_d;
            backlog_q  <= backlog_d;
            lost_q     <= lost_d;
        end
    end

endmodule

// File: tb/tb_bsg_counter_overflow_ctrl.sv
// Self-checking bench for bsg_counter_overflow_ctrl: a small overflow-counter
// model closes the loop and a behavioural model predicts every output.
module tb_bsg_counter_overflow_ctrl;

    localparam int W     = 31;
    localparam int PW    = 8;
    localparam int PMAX  = 3;
    localparam int CTMAX = 3;  // counter model overflows when enabled at this count

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_v;
    logic [W-1:0]  cfg_start;
    logic [PW-1:0] cfg_prescale;
    logic          cfg_ready;
    logic          start, stop;
    logic          ctr_set, ctr_en;
    logic [W-1:0]  ctr_val;
    logic          ctr_overflow;
    logic          tick_v, yumi, lost, busy;
    logic          inject;
    logic [W-1:0]  cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: 0 idle, 1 load, 2 run
    int           m_st, m_pre, m_idx, m_bl;
    logic [W-1:0] m_start;
    logic         m_lost;

    always #5 clk = ~clk;

    bsg_counter_overflow_ctrl #(
        .width_p         (W),
        .prescale_width_p(PW),
        .pending_max_p   (PMAX)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .cfg_v_i       (cfg_v),
        .cfg_start_i   (cfg_start),
        .cfg_prescale_i(cfg_prescale),
`ifdef BSG_COUNTER_OVERFLOW_CTRL_ONESHOT_EN
        .cfg_oneshot_i (1'b0),
`endif
        .cfg_ready_o   (cfg_ready),
        .start_i       (start),
        .stop_i        (stop),
        .ctr_set_o     (ctr_set),
        .ctr_val_o     (ctr_val),
        .ctr_en_o      (ctr_en),
        .ctr_overflow_i(ctr_overflow),
        .tick_v_o      (tick_v),
        .tick_yumi_i   (yumi),
        .lost_o        (lost),
        .busy_o        (busy)
    );

    // Downstream overflow counter: set beats enable; wraps to 0 past CTMAX.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)     cnt <= '0;
        else if (ctr_set) cnt <= ctr_val;
        else if (ctr_en)  cnt <= (cnt == W'(CTMAX)) ? '0 : cnt + 1'b1;
    end

    assign ctr_overflow = (ctr_en && cnt == W'(CTMAX)) || inject;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pre = 0; m_idx = 0; m_bl = 0; m_start = '0; m_lost = 1'b0;
    endtask

    // Compare all outputs against the model, then advance the model by one clock.
    task automatic cycle();
        logic          s_ovf, s_cfg_v, s_start, s_stop, s_yumi;
        logic [W-1:0]  s_cs;
        logic [PW-1:0] s_cp;
        logic          exp_en, ev, yv;
        #1;
        exp_en = (m_st == 2) && ((m_idx % (m_pre + 1)) == m_pre);
        check("busy",      32'(busy),      32'(m_st != 0));
        check("cfg_ready", 32'(cfg_ready), 32'(m_st == 0));
        check("ctr_set",   32'(ctr_set),   32'(m_st == 1 || (m_st == 2 && ctr_overflow)));
        check("ctr_en",    32'(ctr_en),    32'(exp_en));
        check("ctr_val",   32'(ctr_val),   32'(m_start));
        check("tick_v",    32'(tick_v),    32'(m_bl != 0));
        check("lost",      32'(lost),      32'(m_lost));
        s_ovf = ctr_overflow; s_cfg_v = cfg_v; s_start = start; s_stop = stop;
        s_yumi = yumi; s_cs = cfg_start; s_cp = cfg_prescale;
        @(posedge clk);
        ev = (m_st == 2) && s_ovf;
        yv = s_yumi && (m_bl != 0);
        if (ev && !yv) begin
            if (m_bl == PMAX) m_lost = 1'b1;
            else              m_bl++;
        end else if (yv && !ev) begin
            m_bl--;
        end
        case (m_st)
            0: begin
                if (s_cfg_v) begin
                    m_start = s_cs; m_pre = int'(s_cp); m_lost = 1'b0;
                end
                if (s_start && !s_stop) m_st = 1;
            end
            1: begin
                m_st  = s_stop ? 0 : 2;
                m_idx = 0;
            end
            default: begin
                if (s_stop) m_st = 0;
                else        m_idx++;
            end
        endcase
        @(negedge clk);
    endtask

    // Config and start in the same IDLE cycle, then the LOAD cycle; returns at RUN cycle 0.
    task automatic launch(input int sv, input int pv);
        cfg_v = 1'b1; cfg_start = W'(sv); cfg_prescale = PW'(pv); start = 1'b1;
        cycle();
        cfg_v = 1'b0; start = 1'b0;
        cycle();
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && m_bl != 0; k++) begin
            yumi = 1'b1;
            cycle();
        end
        yumi = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_ovf, first_tick, n_ovf, k;

        reset_n = 1'b0; cfg_v = 1'b0; cfg_start = '0; cfg_prescale = '0;
        start = 1'b0; stop = 1'b0; yumi = 1'b0; inject = 1'b0;
        model_reset();
        #12;
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_set",   32'(ctr_set),   32'd0);
        check("rst_en",    32'(ctr_en),    32'd0);
        check("rst_tick",  32'(tick_v),    32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cycle();

        // Divide by 3 with start 0: enables at RUN cycles 2,5,8,11; the
        // counter reaches 3 after the third enable and overflows on the fourth.
        launch(0, 2);
        first_ovf = -1; first_tick = -1;
        for (int j = 0; j < 20; j++) begin
            if (first_ovf < 0 && ctr_overflow) first_ovf = j;
            if (first_tick < 0 && tick_v)      first_tick = j;
            cycle();
        end
        check("div_first_ovf",  32'(first_ovf),  32'd11);
        check("div_first_tick", 32'(first_tick), 32'd12);
        stop = 1'b1; cycle(); stop = 1'b0;
        drain();

        // Reload from 2 with en every cycle: overflow every 2 cycles, never back to 0.
        launch(2, 0);
        n_ovf = 0;
        for (int j = 0; j < 12; j++) begin
            yumi = (m_bl != 0);
            check("reload_nonzero", 32'(cnt != '0), 32'd1);
            if (ctr_overflow) n_ovf++;
            cycle();
        end
        check("reload_ovf_count", 32'(n_ovf), 32'd6);
        yumi = 1'b0;
        stop = 1'b1; cycle(); stop = 1'b0;
        drain();

        // Saturation: five overflows with no yumi.
        launch(2, 0);
        n_ovf = 0;
        for (k = 0; k < 40 && n_ovf < 5; k++) begin
            if (ctr_overflow) n_ovf++;
            cycle();
        end
        check("sat_ovf_count", 32'(n_ovf), 32'd5);
        stop = 1'b1; cycle(); stop = 1'b0;
        check("sat_lost", 32'(lost), 32'd1);
        for (int j = 0; j < 3; j++) begin
            yumi = 1'b1;
            cycle();
        end
        yumi = 1'b0;
        check("sat_drained", 32'(tick_v), 32'd0);
        check("lost_sticky", 32'(lost),   32'd1);
        cfg_v = 1'b1; cfg_start = W'(2); cfg_prescale = '0; cycle(); cfg_v = 1'b0;
        check("lost_cleared", 32'(lost), 32'd0);

        // Overflow coinciding with yumi at backlog 1 keeps the backlog at 1.
        launch(2, 0);
        for (int j = 0; j < 8; j++) begin
            yumi = (m_bl != 0) && ctr_overflow;
            cycle();
        end
        yumi = 1'b0;
        check("simul_hold", 32'(tick_v), 32'd1);

        // Stop on an overflow cycle: event counted, back in IDLE.
        for (k = 0; k < 6 && !ctr_overflow; k++) cycle();
        check("stop_ovf_found", 32'(ctr_overflow), 32'd1);
        stop = 1'b1; cycle(); stop = 1'b0;
        check("stop_ready", 32'(cfg_ready), 32'd1);
        check("stop_tick",  32'(tick_v),    32'd1);

        // Asynchronous reset in RUN with backlog 2.
        launch(2, 0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_ready", 32'(cfg_ready), 32'd1);
        check("arst_busy",  32'(busy),      32'd0);
        check("arst_set",   32'(ctr_set),   32'd0);
        check("arst_en",    32'(ctr_en),    32'd0);
        check("arst_val",   32'(ctr_val),   32'd0);
        check("arst_tick",  32'(tick_v),    32'd0);
        check("arst_lost",  32'(lost),      32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cycle();

        // start and stop together in IDLE stays idle.
        start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
        check("startstop_idle", 32'(busy), 32'd0);
        cycle();

        // Randomised traffic, including stray overflow pulses outside RUN.
        for (int j = 0; j < 3000; j++) begin
            cfg_v        = ($urandom_range(0, 3) == 0);
            cfg_start    = W'($urandom_range(0, 3));
            cfg_prescale = PW'($urandom_range(0, 3));
            start        = ($urandom_range(0, 5) == 0);
            stop         = ($urandom_range(0, 11) == 0);
            inject       = ($urandom_range(0, 9) == 0);
            yumi         = (m_bl != 0) && ($urandom_range(0, 1) == 1);
            cycle();
        end
        cfg_v = 1'b0; start = 1'b0; stop = 1'b0; inject = 1'b0; yumi = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
